ps2_scan_receiver: RTL and testbench

//  Keyboard-side producer of the key_in/key_en scan-code interface consumed by the VGA game controller.

---
 rtl/ps2_scan_receiver.sv | 196 +++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// PS/2 scan-code receiver: frame decode plus set-2 E0/F0 prefix handling, producing key_en/key_rel strobes.
// Latency: key_en/key_rel/parity_err/frame_err rise one vga_clk after the filtered fall that samples the stop bit.
// No backpressure: every decoded event overwrites key_in. Optional macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes.
module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_in,
  output logic       key_en,
  output logic       key_ext,
  output logic       key_rel,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int          FCW     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic            clk_s1, clk_s2, data_s1, data_s2;
  logic            filt_clk, fall_tick;
  logic [FCW-1:0]  filt_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit, par_ok;
  logic [15:0]     to_cnt;
  logic            timeout, byte_valid, perr_c, ferr_c;
  logic            ext_flag, brk_flag;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0]      last_make;
`endif

  // Two-flop synchronizers; reset to the idle-high bus level.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter: accept a new clock level after FILTER_LEN consecutive samples; flag the 1->0 change.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      filt_clk  <= 1'b1;
      filt_cnt  <= '0;
      fall_tick <= 1'b0;
    end else begin
      fall_tick <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == F_LAST) begin
        filt_cnt  <= '0;
        filt_clk  <= clk_s2;
        fall_tick <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign par_ok  = ^{par_bit, shift};
  // A real fall takes precedence over a timeout landing on the same cycle.
  assign timeout = (state != IDLE) && (to_cnt == TO_LAST) && !fall_tick;

  // Frame FSM state register.
  always_ff @(posedge vga_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame FSM next state: moves only on filtered falls, or back to IDLE on timeout.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (fall_tick) begin
      case (state)
        IDLE:    if (!data_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Frame FSM outputs: completed byte or the reason the frame was dropped (stop error beats parity).
  always_comb begin
    byte_valid = 1'b0;
    perr_c     = 1'b0;
    ferr_c     = 1'b0;
    if (timeout) begin
      ferr_c = 1'b1;
    end else if (fall_tick) begin
      if (state == IDLE && data_s2) begin
        ferr_c = 1'b1;
      end else if (state == STOP) begin
        if (!data_s2)     ferr_c     = 1'b1;
        else if (!par_ok) perr_c     = 1'b1;
        else              byte_valid = 1'b1;
      end
    end
  end

  // Frame datapath: LSB-first shifter, bit counter, parity capture and the mid-frame timeout counter.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == IDLE || fall_tick) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 16'd1;
      if (fall_tick) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA:    begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par_bit <= data_s2;
          default: ;
        endcase
      end
    end
  end

  // Scan-code decoder: prefix tracking, event strobes and registered error pulses.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      key_in     <= '0;
      key_en     <= 1'b0;
      key_ext    <= 1'b0;
      key_rel    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      last_make  <= '0;
`endif
    end else begin
      key_en     <= 1'b0;
      key_rel    <= 1'b0;
      parity_err <= perr_c;
      frame_err  <= ferr_c;
      if (byte_valid) begin
        case (shift)
          8'hE0: ext_flag <= 1'b1;
          8'hF0: brk_flag <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF: begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
          end
          default: begin
            key_in   <= shift;
            key_ext  <= ext_flag;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            if (brk_flag) begin
              key_rel <= 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
              if (last_make == {ext_flag, shift}) last_make <= '0;
`endif
            end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
              // 0x00 is never a make code, so a cleared last_make cannot match.
              if (last_make != {ext_flag, shift}) begin
                key_en    <= 1'b1;
                last_make <= {ext_flag, shift};
              end
`else
              key_en <= 1'b1;
`endif
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: PS/2 device model driving frames, scoreboard of expected events.
// Events are checked by a negedge monitor as the DUT emits them; each scenario drains the scoreboard.
// Short PS/2 bit period and reduced timeout keep the run small.
module tb_ps2_scan_receiver;
  localparam int HP = 20;
  localparam int TO = 2000;
  localparam int K_MAKE = 0, K_BRK = 1, K_PERR = 2, K_FERR = 3;

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_in;
  logic       key_en, key_ext, key_rel, parity_err, frame_err;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
    logic       chk_lat;
  } ev_t;

  ev_t  sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stop_cyc = 0;
  logic prev_any = 1'b0;

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc++;

  ps2_scan_receiver #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .vga_clk(vga_clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_in(key_in), .key_en(key_en), .key_ext(key_ext), .key_rel(key_rel),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  // Monitor: pop the scoreboard on every DUT event and compare.
  always @(negedge vga_clk) begin
    int   kind;
    int   lat;
    ev_t  e;
    logic any;
    any = key_en | key_rel | parity_err | frame_err;
    if (any) begin
      kind = key_en ? K_MAKE : key_rel ? K_BRK : parity_err ? K_PERR : K_FERR;
      n_chk++;
      if ($countones({key_en, key_rel, parity_err, frame_err}) != 1) begin
        n_fail++;
        $display("FAIL exclusive: en=%b rel=%b perr=%b ferr=%b, want exactly one", key_en, key_rel, parity_err, frame_err);
      end
      n_chk++;
      if (prev_any) begin
        n_fail++;
        $display("FAIL pulse_width: event high on consecutive cycles at cyc %0d, want single-cycle", cyc);
      end
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: kind %0d key_in %h, scoreboard empty", kind, key_in);
      end else begin
        e = sb.pop_front();
        if (kind !== e.kind) begin
          n_fail++;
          $display("FAIL event_kind: got %0d, want %0d (key_in %h)", kind, e.kind, key_in);
        end
        if (e.kind <= K_BRK) begin
          n_chk++;
          if (key_in !== e.code || key_ext !== e.ext) begin
            n_fail++;
            $display("FAIL event_code: got %h ext %b, want %h ext %b", key_in, key_ext, e.code, e.ext);
          end
        end
        if (e.chk_lat) begin
          lat = cyc - stop_cyc;
          n_chk++;
          if (lat < 4 || lat > 10) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles after last ps2_clk fall, want 4..10", lat);
          end
        end
      end
    end
    prev_any = any;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] code, input logic ext, input logic chk_lat);
    ev_t e;
    e.kind = kind; e.code = code; e.ext = ext; e.chk_lat = chk_lat;
    sb.push_back(e);
  endtask

  // One PS/2 bit: data set while clock high, then a low phase; optional short low glitch in the high phase.
  task automatic send_bit(input logic b, input logic last, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      tick(2); ps2_clk = 1'b0; tick(2); ps2_clk = 1'b1; tick(HP/2 - 4);
    end else begin
      tick(HP/2);
    end
    ps2_clk = 1'b0;
    if (last) stop_cyc = cyc;
    tick(HP);
    ps2_clk = 1'b1;
    tick(HP/2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop, input int glitch_bit);
    logic par;
    par = (~^b) ^ flip_par;
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, glitch_bit == i);
    send_bit(par, 1'b0, 1'b0);
    send_bit(~bad_stop, 1'b1, 1'b0);
    ps2_data = 1'b1;
    tick(2*HP);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, -1);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(i[0], 1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 300) begin tick(1); w++; end
    tick(20);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected events never produced, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(5);
    n_chk++;
    if ({key_in, key_en, key_ext, key_rel, parity_err, frame_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b%b, want all zero", key_in, key_en, key_ext, key_rel, parity_err, frame_err);
    end
    reset = 1'b0;
    tick(20);
    drain("reset_idle");
  endtask

  task automatic test_make();
    expect_ev(K_MAKE, 8'h6B, 1'b0, 1'b1);
    send_byte(8'h6B);
    drain("make");
    n_chk++;
    if (key_in !== 8'h6B) begin
      n_fail++;
      $display("FAIL make_hold: key_in %h, want 6b", key_in);
    end
  endtask

  task automatic test_extended();
    expect_ev(K_MAKE, 8'h74, 1'b1, 1'b1);
    send_byte(8'hE0);
    send_byte(8'h74);
    drain("extended");
  endtask

  task automatic test_break();
    expect_ev(K_BRK, 8'h6B, 1'b0, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h6B);
    drain("break");
  endtask

  task automatic test_typematic();
`ifdef PS2_TYPEMATIC_FILTER_EN
    expect_ev(K_MAKE, 8'h6B, 1'b0, 1'b1);
    expect_ev(K_BRK,  8'h6B, 1'b0, 1'b1);
    expect_ev(K_MAKE, 8'h6B, 1'b0, 1'b1);
`else
    for (int i = 0; i < 3; i++) expect_ev(K_MAKE, 8'h6B, 1'b0, 1'b1);
    expect_ev(K_BRK,  8'h6B, 1'b0, 1'b1);
    expect_ev(K_MAKE, 8'h6B, 1'b0, 1'b1);
`endif
    for (int i = 0; i < 3; i++) send_byte(8'h6B);
    send_byte(8'hF0);
    send_byte(8'h6B);
    send_byte(8'h6B);
    drain("typematic");
  endtask

  task automatic test_parity();
    expect_ev(K_PERR, 8'h00, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b1, 1'b0, -1);
    expect_ev(K_MAKE, 8'h72, 1'b0, 1'b1);
    send_byte(8'h72);
    drain("parity");
  endtask

  task automatic test_frame_err();
    // Bad stop bit together with bad parity: the stop error is reported.
    expect_ev(K_FERR, 8'h00, 1'b0, 1'b1);
    send_frame(8'h35, 1'b1, 1'b1, -1);
    // A high start bit is rejected in IDLE.
    expect_ev(K_FERR, 8'h00, 1'b0, 1'b1);
    send_bit(1'b1, 1'b1, 1'b0);
    tick(2*HP);
    drain("frame_err");
  endtask

  task automatic test_timeout();
    expect_ev(K_FERR, 8'h00, 1'b0, 1'b0);
    send_partial(5);
    ps2_data = 1'b1;
    tick(TO + 200);
    drain("timeout");
    expect_ev(K_MAKE, 8'h1C, 1'b0, 1'b1);
    send_byte(8'h1C);
    drain("after_timeout");
  endtask

  task automatic test_glitch();
    expect_ev(K_MAKE, 8'h29, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b0, 3);
    drain("glitch");
  endtask

  task automatic test_prefix_clear();
    expect_ev(K_MAKE, 8'h6B, 1'b0, 1'b1);
    send_byte(8'hF0);
    send_byte(8'hAA);
    send_byte(8'h6B);
    expect_ev(K_MAKE, 8'h75, 1'b0, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hFA);
    send_byte(8'h75);
    drain("prefix_clear");
  endtask

  task automatic test_reset_midframe();
    send_partial(3);
    ps2_data = 1'b1;
    reset = 1'b1;
    tick(3);
    n_chk++;
    if ({key_in, key_en, key_ext, key_rel, parity_err, frame_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h/%b%b%b%b%b, want all zero", key_in, key_en, key_ext, key_rel, parity_err, frame_err);
    end
    reset = 1'b0;
    tick(TO + 100);
    expect_ev(K_MAKE, 8'h5A, 1'b0, 1'b1);
    send_byte(8'h5A);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_make();
    test_extended();
    test_break();
    test_typematic();
    test_parity();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_prefix_clear();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
